// File: rtl/dc_tfu_pkg.sv
// ============================================================================
// dc_tfu_pkg : shared types for the texel fetch unit (state, texel, quad)
// Revision   : 1.0
// ============================================================================
`default_nettype none

package dc_tfu_pkg;

    localparam int TEXEL_W = 24;

    typedef logic [TEXEL_W-1:0] texel_t;

    // d0=(x,y) d1=(x+1,y) d2=(x,y+1) d3=(x+1,y+1)
    typedef struct packed {
        texel_t d0;
        texel_t d1;
        texel_t d2;
        texel_t d3;
    } quad_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_L_TOP = 3'd1,
        S_RD_L_BOT = 3'd2,
        S_RD_R_TOP = 3'd3,
        S_RD_R_BOT = 3'd4,
        S_CAPTURE  = 3'd5,
        S_EMIT     = 3'd6
    } tfu_state_t;

    typedef enum logic [2:0] {
        TAG_NONE = 3'd0,
        TAG_LT   = 3'd1,
        TAG_LB   = 3'd2,
        TAG_RT   = 3'd3,
        TAG_RB   = 3'd4
    } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/dc_tfu_addr_gen.sv
// ============================================================================
// dc_tfu_addr_gen : clamps row/column to the texture and forms the word address
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dc_tfu_addr_gen #(
    parameter int TEX_SIZE_WIDTH = 12,
    parameter int ADDR_WIDTH     = 20
) (
    input  logic [ADDR_WIDTH-1:0]     base_i,
    input  logic [TEX_SIZE_WIDTH-1:0] stride_i,
    input  logic [TEX_SIZE_WIDTH-1:0] width_i,
    input  logic [TEX_SIZE_WIDTH-1:0] height_i,
    input  logic [TEX_SIZE_WIDTH:0]   row_i,
    input  logic [TEX_SIZE_WIDTH:0]   col_i,
    output logic [ADDR_WIDTH-1:0]     addr_o
);

    localparam int TW = TEX_SIZE_WIDTH;

    // Row/column carry one extra bit so y+1 / x+1 never wrap before clamping.
    function automatic logic [TW:0] clamp(input logic [TW:0] v, input logic [TW-1:0] lim);
        logic [TW:0] top;
        top = {1'b0, lim} - (TW+1)'(1);
        if (lim == '0)
            return '0;
        else if (v > top)
            return top;
        else
            return v;
    endfunction

    logic [TW:0] row_c;
    logic [TW:0] col_c;

    assign row_c  = clamp(row_i, height_i);
    assign col_c  = clamp(col_i, width_i);
    assign addr_o = base_i + ADDR_WIDTH'(row_c) * ADDR_WIDTH'(stride_i) + ADDR_WIDTH'(col_c);

endmodule

`default_nettype wire

// File: rtl/dc_texel_fetch_unit.sv
// ============================================================================
// dc_texel_fetch_unit : streams one row of 2x2 texel quads per accepted request
// Revision            : 1.0
// ============================================================================
`default_nettype none

module dc_texel_fetch_unit
    import dc_tfu_pkg::*;
#(
    parameter int TEX_SIZE_WIDTH = 12,
    parameter int ADDR_WIDTH     = 20
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [ADDR_WIDTH-1:0]     ctl_tex_base,
    input  logic [TEX_SIZE_WIDTH-1:0] ctl_tex_stride,
    input  logic [TEX_SIZE_WIDTH-1:0] ctl_tex_width,
    input  logic [TEX_SIZE_WIDTH-1:0] ctl_tex_height,
    input  logic                      tex_request_valid,
    output logic                      tex_request_ready,
    input  logic [TEX_SIZE_WIDTH-1:0] tex_request_y,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [23:0]               mem_rdata,
    output logic                      texel_valid,
    input  logic                      texel_ready,
    output logic [23:0]               texel_data0,
    output logic [23:0]               texel_data1,
    output logic [23:0]               texel_data2,
    output logic [23:0]               texel_data3,
    output logic                      busy
);

    localparam int TW = TEX_SIZE_WIDTH;

    tfu_state_t            state_q;
    rd_tag_t               tag_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [TW-1:0]         stride_q;
    logic [TW-1:0]         w_q;
    logic [TW-1:0]         h_q;
    logic [TW-1:0]         y_q;
    logic [TW-1:0]         x_q;
    quad_t                 quad_q;
    logic                  rd_en_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  valid_q;

    logic                  is_top;
    logic                  is_left;
    logic [TW:0]           row;
    logic [TW:0]           col;

    assign is_top  = (state_q == S_RD_L_TOP) || (state_q == S_RD_R_TOP) || (state_q == S_IDLE);
    assign is_left = (state_q == S_RD_L_TOP) || (state_q == S_RD_L_BOT) || (state_q == S_IDLE);
    assign row     = is_top  ? {1'b0, y_q} : {1'b0, y_q} + (TW+1)'(1);
    assign col     = is_left ? '0          : {1'b0, x_q} + (TW+1)'(1);

    dc_tfu_addr_gen #(
        .TEX_SIZE_WIDTH (TEX_SIZE_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_addr_gen (
        .base_i   (base_q),
        .stride_i (stride_q),
        .width_i  (w_q),
        .height_i (h_q),
        .row_i    (row),
        .col_i    (col),
        .addr_o   (mem_addr)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            tag_q    <= TAG_NONE;
            base_q   <= '0;
            stride_q <= '0;
            w_q      <= '0;
            h_q      <= '0;
            y_q      <= '0;
            x_q      <= '0;
            quad_q   <= '0;
            rd_en_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            // Read data lands one cycle after its strobe; the tag says where.
            case (tag_q)
                TAG_LT:  quad_q.d0 <= mem_rdata;
                TAG_LB:  quad_q.d2 <= mem_rdata;
                TAG_RT:  quad_q.d1 <= mem_rdata;
                TAG_RB:  quad_q.d3 <= mem_rdata;
                default: ;
            endcase
            tag_q <= TAG_NONE;

            case (state_q)
                S_IDLE: begin
                    if (tex_request_valid) begin
                        base_q   <= ctl_tex_base;
                        stride_q <= ctl_tex_stride;
                        w_q      <= ctl_tex_width;
                        h_q      <= ctl_tex_height;
                        y_q      <= tex_request_y;
                        x_q      <= '0;
                        if ((ctl_tex_width != '0) && (ctl_tex_height != '0)) begin
                            state_q <= S_RD_L_TOP;
                            rd_en_q <= 1'b1;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RD_L_TOP: begin
                    tag_q   <= TAG_LT;
                    state_q <= S_RD_L_BOT;
                end
                S_RD_L_BOT: begin
                    tag_q   <= TAG_LB;
                    state_q <= S_RD_R_TOP;
                end
                S_RD_R_TOP: begin
                    tag_q   <= TAG_RT;
                    state_q <= S_RD_R_BOT;
                end
                S_RD_R_BOT: begin
                    tag_q   <= TAG_RB;
                    rd_en_q <= 1'b0;
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    valid_q <= 1'b1;
                    state_q <= S_EMIT;
                end
                S_EMIT: begin
                    if (texel_ready) begin
                        valid_q <= 1'b0;
                        if (x_q == w_q - TW'(1)) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            quad_q.d0 <= quad_q.d1;
                            quad_q.d2 <= quad_q.d3;
                            x_q       <= x_q + TW'(1);
                            rd_en_q   <= 1'b1;
                            state_q   <= S_RD_R_TOP;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    rd_en_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tex_request_ready = ready_q;
    assign mem_rd_en         = rd_en_q;
    assign texel_valid       = valid_q;
    assign busy              = busy_q;
    assign texel_data0       = quad_q.d0;
    assign texel_data1       = quad_q.d1;
    assign texel_data2       = quad_q.d2;
    assign texel_data3       = quad_q.d3;

endmodule

`default_nettype wire

// File: tb/tb_dc_texel_fetch_unit.sv
// ============================================================================
// tb_dc_texel_fetch_unit : vector table + scoreboard bench for the fetch unit
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_dc_texel_fetch_unit;
    import dc_tfu_pkg::*;

    logic        clk = 1'b0;
    logic        nreset;
    logic [19:0] ctl_tex_base;
    logic [11:0] ctl_tex_stride, ctl_tex_width, ctl_tex_height;
    logic        tex_request_valid;
    logic        tex_request_ready;
    logic [11:0] tex_request_y;
    logic        mem_rd_en;
    logic [19:0] mem_addr;
    logic [23:0] mem_rdata;
    logic        texel_valid;
    logic        texel_ready;
    logic [23:0] texel_data0, texel_data1, texel_data2, texel_data3;
    logic        busy;

    dc_texel_fetch_unit #(.TEX_SIZE_WIDTH(12), .ADDR_WIDTH(20)) dut (
        .clk               (clk),
        .nreset            (nreset),
        .ctl_tex_base      (ctl_tex_base),
        .ctl_tex_stride    (ctl_tex_stride),
        .ctl_tex_width     (ctl_tex_width),
        .ctl_tex_height    (ctl_tex_height),
        .tex_request_valid (tex_request_valid),
        .tex_request_ready (tex_request_ready),
        .tex_request_y     (tex_request_y),
        .mem_rd_en         (mem_rd_en),
        .mem_addr          (mem_addr),
        .mem_rdata         (mem_rdata),
        .texel_valid       (texel_valid),
        .texel_ready       (texel_ready),
        .texel_data0       (texel_data0),
        .texel_data1       (texel_data1),
        .texel_data2       (texel_data2),
        .texel_data3       (texel_data3),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Memory returns its own address as data, one cycle after the strobe.
    always @(posedge clk) mem_rdata <= mem_rd_en ? 24'(mem_addr) : 24'h0;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    accept_cyc = 0;
    int    n_got = 0;
    bit    rand_mode = 1'b0;
    bit    stalled_prev = 1'b0;
    quad_t exp_q[$];
    int    vq[$];
    quad_t held, got_first, got_last, cur;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1 texel_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic texel_t maddr(int base, int stride, int r, int c);
        logic [19:0] a;
        a = 20'(base + r * stride + c);
        return 24'(a);
    endfunction

    function automatic quad_t model_quad(int base, int stride, int w, int h, int y, int x);
        quad_t q;
        int y0, y1, cr;
        y0 = (y > h - 1) ? h - 1 : y;
        y1 = (y0 + 1 > h - 1) ? h - 1 : y0 + 1;
        cr = (x + 1 > w - 1) ? w - 1 : x + 1;
        q.d0 = maddr(base, stride, y0, x);
        q.d1 = maddr(base, stride, y0, cr);
        q.d2 = maddr(base, stride, y1, x);
        q.d3 = maddr(base, stride, y1, cr);
        return q;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard: push model quads at accept, pop on each handshake.
    always @(negedge clk) begin
        if (!nreset) begin
            stalled_prev = 1'b0;
        end else begin
            chk("ready_vs_busy", 96'(tex_request_ready), 96'(!busy));
            if (tex_request_valid && tex_request_ready) begin
                accept_cyc = cyc;
                n_got = 0;
                vq.delete();
                if (ctl_tex_width != 0 && ctl_tex_height != 0)
                    for (int x = 0; x < int'(ctl_tex_width); x++)
                        exp_q.push_back(model_quad(int'(ctl_tex_base), int'(ctl_tex_stride),
                            int'(ctl_tex_width), int'(ctl_tex_height), int'(tex_request_y), x));
            end
            if (texel_valid) begin
                cur = '{texel_data0, texel_data1, texel_data2, texel_data3};
                if (stalled_prev) chk("stall_stable", cur, held);
                else vq.push_back(cyc);
                if (!texel_ready) begin
                    chk("stall_no_read", 96'(mem_rd_en), 96'(0));
                    held = cur;
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_quad: got %h expected none", cur);
                    end else begin
                        chk("quad", cur, exp_q.pop_front());
                    end
                    if (n_got == 0) got_first = cur;
                    got_last = cur;
                    n_got++;
                end
                stalled_prev = !texel_ready;
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    task automatic do_request(input logic [11:0] y);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        tex_request_y = y;
        tex_request_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tex_request_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin checks++; errors++; $display("FAIL accept_timeout: got ready=0 expected 1"); end
        @(posedge clk); #1;
        tex_request_valid = 1'b0;
        // Later control changes must not disturb the transfer just accepted.
        ctl_tex_base   = 20'($urandom);
        ctl_tex_stride = 12'($urandom);
        ctl_tex_width  = 12'($urandom);
        ctl_tex_height = 12'($urandom);
        tex_request_y  = 12'($urandom);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin checks++; errors++; $display("FAIL done_timeout: got busy=%0b expected 0", busy); end
        repeat (6) @(negedge clk);
    endtask

    task automatic set_ctl(input logic [19:0] b, input logic [11:0] s, input logic [11:0] w, input logic [11:0] h);
        ctl_tex_base = b; ctl_tex_stride = s; ctl_tex_width = w; ctl_tex_height = h;
    endtask

    typedef struct {
        logic [19:0] base;
        logic [11:0] stride, w, h, y;
        bit          rnd;
        int          n;
        quad_t       first, last;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{20'h100, 12'd8, 12'd8, 12'd8, 12'd2, 1'b0, 8,
                    '{24'h110, 24'h111, 24'h118, 24'h119}, '{24'h117, 24'h117, 24'h11F, 24'h11F}};
        vecs[1] = '{20'h100, 12'd8, 12'd8, 12'd8, 12'd7, 1'b0, 8,
                    '{24'h138, 24'h139, 24'h138, 24'h139}, '{24'h13F, 24'h13F, 24'h13F, 24'h13F}};
        vecs[2] = '{20'h100, 12'd8, 12'd8, 12'd8, 12'd12, 1'b0, 8,
                    '{24'h138, 24'h139, 24'h138, 24'h139}, '{24'h13F, 24'h13F, 24'h13F, 24'h13F}};
        vecs[3] = '{20'h100, 12'd8, 12'd8, 12'd8, 12'd2, 1'b1, 8,
                    '{24'h110, 24'h111, 24'h118, 24'h119}, '{24'h117, 24'h117, 24'h11F, 24'h11F}};
        vecs[4] = '{20'h100, 12'd8, 12'd1, 12'd8, 12'd0, 1'b0, 1,
                    '{24'h100, 24'h100, 24'h108, 24'h108}, '{24'h100, 24'h100, 24'h108, 24'h108}};
        vecs[5] = '{20'h100, 12'd8, 12'd0, 12'd8, 12'd0, 1'b0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[6] = '{20'h100, 12'd8, 12'd8, 12'd0, 12'd0, 1'b0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[7] = '{20'hFFFF0, 12'd16, 12'd4, 12'd2, 12'd1, 1'b0, 4,
                    '{24'h0, 24'h1, 24'h0, 24'h1}, '{24'h3, 24'h3, 24'h3, 24'h3}};

        nreset = 1'b0;
        tex_request_valid = 1'b0;
        tex_request_y = '0;
        set_ctl(20'h0, 12'd0, 12'd0, 12'd0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 96'(tex_request_ready), 96'(1));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_valid", 96'(texel_valid), 96'(0));
        chk("rst_rd_en", 96'(mem_rd_en), 96'(0));
        chk("rst_addr", 96'(mem_addr), 96'(0));
        chk("rst_data", {texel_data0, texel_data1, texel_data2, texel_data3}, 96'(0));
        @(posedge clk); #1 nreset = 1'b1;

        foreach (vecs[i]) begin
            rand_mode = vecs[i].rnd;
            set_ctl(vecs[i].base, vecs[i].stride, vecs[i].w, vecs[i].h);
            do_request(vecs[i].y);
            wait_done();
            chk($sformatf("v%0d_count", i), 96'(n_got), 96'(vecs[i].n));
            if (vecs[i].n > 0) begin
                chk($sformatf("v%0d_first", i), got_first, vecs[i].first);
                chk($sformatf("v%0d_last", i), got_last, vecs[i].last);
            end
            chk($sformatf("v%0d_ready_after", i), 96'(tex_request_ready), 96'(1));
        end
        rand_mode = 1'b0;

        // Latency and steady-state quad spacing with texel_ready held high.
        set_ctl(20'h100, 12'd8, 12'd8, 12'd8);
        do_request(12'd2);
        wait_done();
        chk("latency_first", 96'(vq.size() > 0 ? vq[0] - accept_cyc : -1), 96'(6));
        chk("quad_spacing", 96'(vq.size() > 1 ? vq[1] - vq[0] : -1), 96'(4));

        // Reset part-way through a row abandons the remaining quads.
        set_ctl(20'h100, 12'd8, 12'd8, 12'd8);
        do_request(12'd2);
        for (int i = 0; i < 200 && n_got < 3; i++) @(negedge clk);
        chk("pre_reset_quads", 96'(n_got), 96'(3));
        @(posedge clk); #1 nreset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 nreset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 96'(tex_request_ready), 96'(1));
        chk("mid_rst_busy", 96'(busy), 96'(0));
        chk("mid_rst_data", {texel_data0, texel_data1, texel_data2, texel_data3}, 96'(0));
        begin
            int stale = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (texel_valid || mem_rd_en) stale++;
            end
            chk("no_stale_quads", 96'(stale), 96'(0));
        end
        set_ctl(20'h100, 12'd8, 12'd8, 12'd8);
        do_request(12'd0);
        wait_done();
        chk("post_rst_first", got_first, {24'h100, 24'h101, 24'h108, 24'h109});
        chk("post_rst_count", 96'(n_got), 96'(8));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
